// File: rtl/buf_alu_arbiter_if.sv
// Bus bundle between two requesters, the shared ALU and the arbiter.
// Handshake: a request transfers in a cycle where reqN_valid and reqN_ready
// are both high; ready is combinational from valid and the arbiter state,
// and a requester must hold valid and its func/a/b stable until it sees ready.
// resp_valid is a one-cycle completion strobe with no back-pressure.
interface buf_alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [3:0]       req0_func;
  logic [3:0]       req1_func;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             alu_en;
  logic [3:0]       alu_func;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_c;
  logic             alu_n;
  logic             alu_z;

  logic             resp_valid;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;
  logic [2:0]       ccr;
  logic             busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req1_valid, req0_func, req1_func,
    input  req0_a, req0_b, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_en, alu_func, alu_a, alu_b,
    input  alu_out, alu_c, alu_n, alu_z,
    output resp_valid, resp_id, resp_data, resp_err, ccr, busy
  );

  // Requester and ALU side.
  modport master (
    output req0_valid, req1_valid, req0_func, req1_func,
    output req0_a, req0_b, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_en, alu_func, alu_a, alu_b,
    output alu_out, alu_c, alu_n, alu_z,
    input  resp_valid, resp_id, resp_data, resp_err, ccr, busy
  );
endinterface

// File: rtl/buf_alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// One operation is in flight at a time: IDLE accepts, ISSUE pulses alu_en,
// WAIT counts down the ALU latency, RESP returns the result and updates CCR.
// Illegal function codes bypass the ALU and answer with resp_err.
module buf_alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  buf_alu_arbiter_if.slave  bus,
  output logic [1:0]        o_dbg_state
);

  localparam logic [3:0] FN_LDD = 4'b0001;
  localparam logic [3:0] FN_ADD = 4'b0011;
  localparam logic [3:0] FN_NOT = 4'b0100;
  localparam logic [3:0] FN_NOP = 4'b0101;

  localparam logic [1:0] LAT_LOAD = 2'(LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic             w_any_valid;
  logic             w_grant_id;
  logic [3:0]       w_sel_func;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_legal;
  logic             w_accept;
  logic             w_sample;
  logic             w_req0_ready;
  logic             w_req1_ready;

  logic             r_last_id;
  logic [1:0]       r_cnt;
  logic [3:0]       r_func;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_resp_id;
  logic             r_resp_err;
  logic [2:0]       r_ccr;

  // Grant selection: with both requesting, the one not served last wins.
  always_comb begin
    w_any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_id = ~r_last_id;
    end else begin
      w_grant_id = bus.req1_valid;
    end
    w_sel_func  = w_grant_id ? bus.req1_func : bus.req0_func;
    w_sel_a     = w_grant_id ? bus.req1_a    : bus.req0_a;
    w_sel_b     = w_grant_id ? bus.req1_b    : bus.req0_b;
    w_sel_legal = (w_sel_func >= FN_LDD) && (w_sel_func <= FN_NOP);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode; nothing is accepted while in reset.
  always_comb begin
    w_next_state = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_accept     = 1'b1;
          w_req0_ready = ~w_grant_id;
          w_req1_ready = w_grant_id;
          w_next_state = w_sel_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        // Counter reaches zero on this edge: the ALU result is valid now.
        if (r_cnt == 2'd1) begin
          w_sample     = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (!rst) begin
      w_req0_ready = 1'b0;
      w_req1_ready = 1'b0;
      w_accept     = 1'b0;
      w_sample     = 1'b0;
    end
  end

  // Capture the granted request and remember who was served.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_func    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= 1'b0;
      r_last_id <= 1'b1;
    end else if (w_accept) begin
      r_func    <= w_sel_func;
      r_a       <= w_sel_a;
      r_b       <= w_sel_b;
      r_id      <= w_grant_id;
      r_last_id <= w_grant_id;
    end
  end

  // ALU latency counter: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 2'd0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= LAT_LOAD;
    end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  // Response holding registers and condition codes; loaded on entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_resp_data <= '0;
      r_resp_id   <= 1'b0;
      r_resp_err  <= 1'b0;
      r_ccr       <= 3'b000;
    end else if (w_sample) begin
      r_resp_data <= bus.alu_out;
      r_resp_id   <= r_id;
      r_resp_err  <= 1'b0;
      if ((r_func == FN_ADD) || (r_func == FN_NOT)) begin
        r_ccr <= {bus.alu_c, bus.alu_n, bus.alu_z};
      end
    end else if (w_accept && !w_sel_legal) begin
      r_resp_data <= '0;
      r_resp_id   <= w_grant_id;
      r_resp_err  <= 1'b1;
    end
  end

  assign bus.req0_ready = w_req0_ready;
  assign bus.req1_ready = w_req1_ready;
  assign bus.alu_en     = (r_state == S_ISSUE);
  assign bus.alu_func   = r_func;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;
  assign bus.ccr        = r_ccr;
  assign bus.busy       = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_buf_alu_arbiter.sv
// Directed bench: three arbiters (LAT=1,2,3) share one stimulus stream,
// each with its own ALU model; sel picks which one is observed.
module tb_buf_alu_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid;
  logic [3:0]  req0_func, req1_func;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  sel;
  logic [1:0]  dbg [3];

  int checks;
  int failures;

  typedef struct packed {
    logic        r0;
    logic        r1;
    logic        en;
    logic [3:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic        rv;
    logic        rid;
    logic [15:0] rdata;
    logic        rerr;
    logic [2:0]  ccr;
    logic        busy;
  } obs_t;

  obs_t obs [3];
  obs_t m;

  // Reference ALU: returns {C, N, Z, result}.
  function automatic logic [18:0] alu_model(input logic [3:0] f, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] sum;
    logic [15:0] y;
    logic        c;
    c   = 1'b0;
    y   = 16'h0000;
    sum = 17'h0;
    case (f)
      4'h1: y = a;
      4'h2: y = b;
      4'h3: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[15:0];
        c   = sum[16];
      end
      4'h4: y = ~b;
      default: y = 16'h0000;
    endcase
    return {c, y[15], (y == 16'h0000), y};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    buf_alu_arbiter_if #(.WIDTH(16)) u_if ();

    buf_alu_arbiter #(.WIDTH(16), .LAT(g + 1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (u_if),
      .o_dbg_state (dbg[g])
    );

    assign u_if.req0_valid = req0_valid;
    assign u_if.req1_valid = req1_valid;
    assign u_if.req0_func  = req0_func;
    assign u_if.req1_func  = req1_func;
    assign u_if.req0_a     = req0_a;
    assign u_if.req0_b     = req0_b;
    assign u_if.req1_a     = req1_a;
    assign u_if.req1_b     = req1_b;
    assign {u_if.alu_c, u_if.alu_n, u_if.alu_z, u_if.alu_out} =
      alu_model(u_if.alu_func, u_if.alu_a, u_if.alu_b);
    assign obs[g] = {u_if.req0_ready, u_if.req1_ready, u_if.alu_en, u_if.alu_func,
                     u_if.alu_a, u_if.alu_b, u_if.resp_valid, u_if.resp_id,
                     u_if.resp_data, u_if.resp_err, u_if.ccr, u_if.busy};
  end

  always_comb m = obs[sel];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic id, input logic v, input logic [3:0] f,
                       input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      req1_valid = v; req1_func = f; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_func = f; req0_a = a; req0_b = b;
    end
  endtask

  // Present one request, then watch until its response (bounded).
  // Cycle numbers are relative to the accept cycle T.
  task automatic run_op(input logic id, input logic [3:0] f, input logic [15:0] a,
                        input logic [15:0] b, output int en_cnt, output int en_cyc,
                        output int resp_cyc, output obs_t at_en, output obs_t at_resp,
                        output obs_t after);
    en_cnt = 0; en_cyc = -1; resp_cyc = -1;
    at_en = '0; at_resp = '0; after = '0;
    drive(id, 1'b1, f, a, b);
    @(negedge clk);
    check("accept_ready", {30'd0, m.r1, m.r0}, id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    drive(id, 1'b0, f, a, b);
    for (int n = 1; n <= 12 && resp_cyc < 0; n++) begin
      @(negedge clk);
      if (m.en) begin en_cnt++; en_cyc = n; at_en = m; end
      if (m.rv) begin resp_cyc = n; at_resp = m; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    after = m;
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          en_cnt, en_cyc, resp_cyc;
    obs_t        e, r, a;
    logic [16:0] exp_q[$];
    logic [16:0] item;
    logic        exp_grant;
    logic        seen_rv;
    int          last_acc, n_acc;

    checks = 0; failures = 0; sel = 2'd0;
    rst = 1'b0;
    drive(1'b0, 1'b1, 4'h3, 16'h0, 16'h0);
    drive(1'b1, 1'b1, 4'h3, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  m.busy,  0);
    check("rst_alu_en", m.en,   0);
    check("rst_func",  m.func,  0);
    check("rst_alu_a", m.a,     0);
    check("rst_alu_b", m.b,     0);
    check("rst_rv",    m.rv,    0);
    check("rst_rid",   m.rid,   0);
    check("rst_rdata", m.rdata, 0);
    check("rst_rerr",  m.rerr,  0);
    check("rst_ccr",   m.ccr,   0);
    check("rst_ready", {m.r1, m.r0}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;

    // Single ADD, LAT=1.
    run_op(1'b0, 4'h3, 16'h7FFF, 16'h0001, en_cnt, en_cyc, resp_cyc, e, r, a);
    check("add_en_cyc",   en_cyc, 1);
    check("add_en_cnt",   en_cnt, 1);
    check("add_en_func",  e.func, 4'h3);
    check("add_en_a",     e.a, 16'h7FFF);
    check("add_en_b",     e.b, 16'h0001);
    check("add_resp_cyc", resp_cyc, 3);
    check("add_rid",      r.rid, 0);
    check("add_rdata",    r.rdata, 16'h8000);
    check("add_rerr",     r.rerr, 0);
    check("add_hold_a",   r.a, 16'h7FFF);
    check("add_rv_1cyc",  a.rv, 0);
    check("add_idle",     a.busy, 0);
    check("add_ccr",      a.ccr, 3'b010);

    // ADD overflow from req1, then LDD leaves CCR alone.
    run_op(1'b1, 4'h3, 16'hFFFF, 16'h0001, en_cnt, en_cyc, resp_cyc, e, r, a);
    check("ovf_rid",   r.rid, 1);
    check("ovf_rdata", r.rdata, 16'h0000);
    check("ovf_ccr",   a.ccr, 3'b101);
    run_op(1'b0, 4'h1, 16'h1234, 16'h0000, en_cnt, en_cyc, resp_cyc, e, r, a);
    check("ldd_rdata", r.rdata, 16'h1234);
    check("ldd_ccr",   a.ccr, 3'b101);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_rdata", m.rdata, 16'h1234);
    check("hold_rid",   m.rid, 0);
    check("hold_rv",    m.rv, 0);
    @(posedge clk); #1;

    // Illegal function from req1.
    run_op(1'b1, 4'hF, 16'hAAAA, 16'h5555, en_cnt, en_cyc, resp_cyc, e, r, a);
    check("ill_en_cnt",   en_cnt, 0);
    check("ill_resp_cyc", resp_cyc, 1);
    check("ill_rerr",     r.rerr, 1);
    check("ill_rdata",    r.rdata, 0);
    check("ill_rid",      r.rid, 1);
    check("ill_ccr",      a.ccr, 3'b101);

    // Contention: both valid, grants alternate starting with req0.
    drive(1'b0, 1'b1, 4'h1, 16'h1111, 16'h0000);
    drive(1'b1, 1'b1, 4'h2, 16'h0000, 16'h2222);
    exp_grant = 1'b0; last_acc = -1; n_acc = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (m.r0 || m.r1) begin
        check("rr_grant", {m.r1, m.r0}, exp_grant ? 32'd2 : 32'd1);
        if (last_acc >= 0) check("rr_spacing", c - last_acc, 4);
        exp_q.push_back(m.r1 ? {1'b1, 16'h2222} : {1'b0, 16'h1111});
        last_acc = c; n_acc++; exp_grant = ~exp_grant;
      end
      if (m.rv) begin
        check("rr_resp_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          item = exp_q.pop_front();
          check("rr_resp_id",   m.rid, item[16]);
          check("rr_resp_data", m.rdata, item[15:0]);
        end
      end
      @(posedge clk); #1;
      if (c == 15) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    check("rr_accepts", n_acc, 4);
    check("rr_q_empty", exp_q.size(), 0);
    check("rr_ccr",     m.ccr, 3'b101);
    repeat (8) @(posedge clk);
    #1;

    // LAT=2: NOT.
    sel = 2'd1;
    run_op(1'b0, 4'h4, 16'h0000, 16'h00FF, en_cnt, en_cyc, resp_cyc, e, r, a);
    check("lat2_en_cyc",   en_cyc, 1);
    check("lat2_resp_cyc", resp_cyc, 4);
    check("lat2_rdata",    r.rdata, 16'hFF00);
    check("lat2_ccr",      a.ccr, 3'b010);
    repeat (8) @(posedge clk);
    #1;

    // LAT=3: set CCR, then reset during WAIT.
    sel = 2'd2;
    run_op(1'b1, 4'h3, 16'hFFFF, 16'h0001, en_cnt, en_cyc, resp_cyc, e, r, a);
    check("lat3_resp_cyc", resp_cyc, 5);
    check("lat3_ccr",      a.ccr, 3'b101);
    drive(1'b0, 1'b1, 4'h3, 16'h7FFF, 16'h0001);
    @(negedge clk);
    check("wrst_accept", {m.r1, m.r0}, 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h3, 16'h7FFF, 16'h0001);
    @(negedge clk);
    check("wrst_issue", m.en, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("wrst_in_wait", m.busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("wrst_busy", m.busy, 0);
    check("wrst_ccr",  m.ccr, 0);
    seen_rv = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      seen_rv = seen_rv | m.rv;
    end
    check("wrst_no_resp", seen_rv, 0);
    check("wrst_ccr_kept", m.ccr, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'h5, 16'h0, 16'h0);
    drive(1'b1, 1'b1, 4'h5, 16'h0, 16'h0);
    @(negedge clk);
    check("wrst_req0_first", {m.r1, m.r0}, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (8) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
